alu_cmd_driver: RTL and testbench

Initiator side of the 16-bit ALU operand/function interface. Accepts operation commands over a valid/ready port and drives A/B/ALU_FUN into the registered ALU. It waits out the ALU latency, then captures ALU_OUT and the five flags. The captured result is returned over a valid/ready response port. It sits between a command source (sequencer/CPU stub) and the ALU.

---
 rtl/alu_pkg.sv | 37 +++
 rtl/alu_ref_model.sv | 51 +++++
 rtl/alu_cmd_driver.sv | 182 ++++++++++++++++++
 tb/tb_alu_cmd_driver.sv | 270 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/alu_pkg.sv
// Shared definitions for the ALU command driver: function codes, flag bit
// positions and driver state encoding.
package alu_pkg;

  localparam int FLAG_W = 5;

  localparam logic [3:0] ALU_ADD  = 4'b0000;
  localparam logic [3:0] ALU_SUB  = 4'b0001;
  localparam logic [3:0] ALU_MUL  = 4'b0010;
  localparam logic [3:0] ALU_DIV  = 4'b0011;
  localparam logic [3:0] ALU_AND  = 4'b0100;
  localparam logic [3:0] ALU_OR   = 4'b0101;
  localparam logic [3:0] ALU_NAND = 4'b0110;
  localparam logic [3:0] ALU_NOR  = 4'b0111;
  localparam logic [3:0] ALU_XOR  = 4'b1000;
  localparam logic [3:0] ALU_XNOR = 4'b1001;
  localparam logic [3:0] ALU_EQ   = 4'b1010;
  localparam logic [3:0] ALU_GT   = 4'b1011;
  localparam logic [3:0] ALU_LT   = 4'b1100;
  localparam logic [3:0] ALU_SHR  = 4'b1101;
  localparam logic [3:0] ALU_SHL  = 4'b1110;
  localparam logic [3:0] ALU_NOP  = 4'b1111;

  // Flag vector layout is {carry, arith, logic, cmp, shift}
  localparam int FLAG_CARRY = 4;
  localparam int FLAG_ARITH = 3;
  localparam int FLAG_LOGIC = 2;
  localparam int FLAG_CMP   = 1;
  localparam int FLAG_SHIFT = 0;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_WAIT = 2'd1,
    ST_RESP = 2'd2
  } state_e;

endpackage

// File: rtl/alu_ref_model.sv
// Combinational golden model of the 16-bit ALU, used by the driver's
// self-check path when ALU_DRV_CHECK_EN is defined.
module alu_ref_model
  import alu_pkg::*;
(
  input  logic [3:0]        fun_i,
  input  logic [15:0]       a_i,
  input  logic [15:0]       b_i,
  output logic [15:0]       out_o,
  output logic [FLAG_W-1:0] flags_o
);

  logic [16:0] sum;

  always_comb begin
    out_o   = 16'h0000;
    flags_o = '0;
    sum     = 17'h0_0000;
    case (fun_i)
      ALU_ADD: begin
        sum = {1'b0, a_i} + {1'b0, b_i};
        out_o = sum[15:0];
        flags_o[FLAG_CARRY] = sum[16];
      end
      ALU_SUB: begin
        out_o = a_i - b_i;
        flags_o[FLAG_CARRY] = (a_i < b_i);
      end
      ALU_MUL:  out_o = a_i * b_i;
      ALU_DIV:  out_o = (b_i == 16'h0000) ? 16'h0000 : a_i / b_i;
      ALU_AND:  out_o = a_i & b_i;
      ALU_OR:   out_o = a_i | b_i;
      ALU_NAND: out_o = ~(a_i & b_i);
      ALU_NOR:  out_o = ~(a_i | b_i);
      ALU_XOR:  out_o = a_i ^ b_i;
      ALU_XNOR: out_o = ~(a_i ^ b_i);
      ALU_EQ:   out_o = (a_i == b_i) ? 16'd1 : 16'd0;
      ALU_GT:   out_o = (a_i > b_i)  ? 16'd2 : 16'd0;
      ALU_LT:   out_o = (a_i < b_i)  ? 16'd3 : 16'd0;
      ALU_SHR:  out_o = a_i >> 1;
      ALU_SHL:  out_o = a_i << 1;
      default:  out_o = 16'h0000;
    endcase

    if (fun_i <= ALU_DIV)       flags_o[FLAG_ARITH] = 1'b1;
    else if (fun_i <= ALU_XNOR) flags_o[FLAG_LOGIC] = 1'b1;
    else if (fun_i <= ALU_LT)   flags_o[FLAG_CMP]   = 1'b1;
    else if (fun_i <= ALU_SHL)  flags_o[FLAG_SHIFT] = 1'b1;
  end

endmodule

// File: rtl/alu_cmd_driver.sv
// Initiator for the registered 16-bit ALU: takes commands, waits out the ALU
// latency, returns result/flags. Define ALU_DRV_CHECK_EN to enable self-check.
module alu_cmd_driver
  import alu_pkg::*;
#(
  parameter int ALU_LAT = 1,
  parameter int CNT_W   = 16
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              cmd_valid,
  output logic              cmd_ready,
  input  logic [3:0]        cmd_fun,
  input  logic [15:0]       cmd_a,
  input  logic [15:0]       cmd_b,
  output logic [15:0]       alu_a,
  output logic [15:0]       alu_b,
  output logic [3:0]        alu_fun,
  input  logic [15:0]       alu_out,
  input  logic              alu_carry,
  input  logic              alu_arith,
  input  logic              alu_logic,
  input  logic              alu_cmp,
  input  logic              alu_shift,
  output logic              rsp_valid,
  input  logic              rsp_ready,
  output logic [15:0]       rsp_data,
  output logic [FLAG_W-1:0] rsp_flags,
  output logic              rsp_err,
  output logic              busy,
  output logic [CNT_W-1:0]  txn_count,
  output logic [7:0]        err_count
);

  localparam int LAT_W = $clog2(ALU_LAT + 1);

  state_e             state_q, state_d;
  logic [LAT_W-1:0]   cnt_q, cnt_d;
  logic [15:0]        alu_a_q, alu_a_d;
  logic [15:0]        alu_b_q, alu_b_d;
  logic [3:0]         alu_fun_q, alu_fun_d;
  logic               rsp_valid_q, rsp_valid_d;
  logic [15:0]        rsp_data_q, rsp_data_d;
  logic [FLAG_W-1:0]  rsp_flags_q, rsp_flags_d;
  logic [CNT_W-1:0]   txn_q, txn_d;
  logic [FLAG_W-1:0]  flags_in;
  logic               capture;

  assign flags_in = {alu_carry, alu_arith, alu_logic, alu_cmp, alu_shift};
  assign capture  = (state_q == ST_WAIT) && (cnt_q == '0);

  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    alu_a_d     = alu_a_q;
    alu_b_d     = alu_b_q;
    alu_fun_d   = alu_fun_q;
    rsp_valid_d = rsp_valid_q;
    rsp_data_d  = rsp_data_q;
    rsp_flags_d = rsp_flags_q;
    txn_d       = txn_q;
    case (state_q)
      ST_IDLE: begin
        if (cmd_valid) begin
          alu_a_d   = cmd_a;
          alu_b_d   = cmd_b;
          alu_fun_d = cmd_fun;
          cnt_d     = LAT_W'(ALU_LAT);
          state_d   = ST_WAIT;
        end
      end
      ST_WAIT: begin
        if (capture) begin
          rsp_data_d  = alu_out;
          rsp_flags_d = flags_in;
          rsp_valid_d = 1'b1;
          // Park the ALU on the no-op code between transactions
          alu_fun_d   = ALU_NOP;
          alu_a_d     = 16'h0000;
          alu_b_d     = 16'h0000;
          state_d     = ST_RESP;
        end else begin
          cnt_d = cnt_q - LAT_W'(1);
        end
      end
      ST_RESP: begin
        if (rsp_ready) begin
          rsp_valid_d = 1'b0;
          txn_d       = txn_q + CNT_W'(1);
          state_d     = ST_IDLE;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= ST_IDLE;
      cnt_q       <= '0;
      alu_a_q     <= 16'h0000;
      alu_b_q     <= 16'h0000;
      alu_fun_q   <= ALU_NOP;
      rsp_valid_q <= 1'b0;
      rsp_data_q  <= 16'h0000;
      rsp_flags_q <= '0;
      txn_q       <= '0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      alu_a_q     <= alu_a_d;
      alu_b_q     <= alu_b_d;
      alu_fun_q   <= alu_fun_d;
      rsp_valid_q <= rsp_valid_d;
      rsp_data_q  <= rsp_data_d;
      rsp_flags_q <= rsp_flags_d;
      txn_q       <= txn_d;
    end
  end

  assign cmd_ready = (state_q == ST_IDLE);
  assign busy      = (state_q != ST_IDLE);
  assign alu_a     = alu_a_q;
  assign alu_b     = alu_b_q;
  assign alu_fun   = alu_fun_q;
  assign rsp_valid = rsp_valid_q;
  assign rsp_data  = rsp_data_q;
  assign rsp_flags = rsp_flags_q;
  assign txn_count = txn_q;

`ifdef ALU_DRV_CHECK_EN
  logic [3:0]        chk_fun_q;
  logic [15:0]       chk_a_q, chk_b_q;
  logic [15:0]       exp_out;
  logic [FLAG_W-1:0] exp_flags;
  logic              carry_chk;
  logic              mismatch;
  logic              rsp_err_q;
  logic [7:0]        err_cnt_q;

  alu_ref_model u_ref (
    .fun_i   (chk_fun_q),
    .a_i     (chk_a_q),
    .b_i     (chk_b_q),
    .out_o   (exp_out),
    .flags_o (exp_flags)
  );

  // Carry is only meaningful for add/sub; other codes leave it unspecified
  assign carry_chk = (chk_fun_q == ALU_ADD) || (chk_fun_q == ALU_SUB);
  assign mismatch  = (exp_out != alu_out)
                  || (exp_flags[FLAG_ARITH:0] != flags_in[FLAG_ARITH:0])
                  || (carry_chk && (exp_flags[FLAG_CARRY] != alu_carry));

  always_ff @(posedge clk) begin
    if (rst) begin
      chk_fun_q <= ALU_NOP;
      chk_a_q   <= 16'h0000;
      chk_b_q   <= 16'h0000;
      rsp_err_q <= 1'b0;
      err_cnt_q <= 8'h00;
    end else begin
      if ((state_q == ST_IDLE) && cmd_valid) begin
        chk_fun_q <= cmd_fun;
        chk_a_q   <= cmd_a;
        chk_b_q   <= cmd_b;
      end
      if (capture) begin
        rsp_err_q <= mismatch;
        if (mismatch && (err_cnt_q != 8'hFF)) err_cnt_q <= err_cnt_q + 8'h01;
      end
    end
  end

  assign rsp_err   = rsp_err_q;
  assign err_count = err_cnt_q;
`else
  assign rsp_err   = 1'b0;
  assign err_count = 8'h00;
`endif

endmodule

// File: tb/tb_alu_cmd_driver.sv
// Directed bench for alu_cmd_driver with a 1-cycle registered ALU stub.
// Extra self-check scenario runs when ALU_DRV_CHECK_EN is defined.
module tb_alu_cmd_driver;

  logic        clk = 1'b0;
  logic        rst;
  logic        cmd_valid, cmd_ready;
  logic [3:0]  cmd_fun;
  logic [15:0] cmd_a, cmd_b;
  logic [15:0] alu_a, alu_b;
  logic [3:0]  alu_fun;
  logic [15:0] alu_out;
  logic        alu_carry, alu_arith, alu_logic, alu_cmp, alu_shift;
  logic        rsp_valid, rsp_ready;
  logic [15:0] rsp_data;
  logic [4:0]  rsp_flags;
  logic        rsp_err, busy;
  logic [15:0] txn_count;
  logic [7:0]  err_count;

  int tests = 0;
  int fails = 0;
  int cyc   = 0;
  logic force_bad = 1'b0;

  alu_cmd_driver #(.ALU_LAT(1), .CNT_W(16)) dut (
    .clk(clk), .rst(rst),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_fun(cmd_fun),
    .cmd_a(cmd_a), .cmd_b(cmd_b),
    .alu_a(alu_a), .alu_b(alu_b), .alu_fun(alu_fun), .alu_out(alu_out),
    .alu_carry(alu_carry), .alu_arith(alu_arith), .alu_logic(alu_logic),
    .alu_cmp(alu_cmp), .alu_shift(alu_shift),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_data(rsp_data),
    .rsp_flags(rsp_flags), .rsp_err(rsp_err), .busy(busy),
    .txn_count(txn_count), .err_count(err_count)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  // ALU stub: {carry,arith,logic,cmp,shift,out}
  function automatic logic [20:0] alu_f(input logic [3:0] f, input logic [15:0] a, input logic [15:0] b);
    logic [16:0] s;
    logic [15:0] o;
    logic [4:0]  fl;
    s = 17'h0; o = 16'h0; fl = 5'b0;
    case (f)
      4'h0: begin s = {1'b0, a} + {1'b0, b}; o = s[15:0]; fl = {s[16], 4'b1000}; end
      4'h1: begin o = a - b; fl = {(a < b), 4'b1000}; end
      4'h2: begin o = a * b; fl = 5'b01000; end
      4'h3: begin o = (b == 16'h0) ? 16'h0 : a / b; fl = 5'b01000; end
      4'h4: begin o = a & b; fl = 5'b00100; end
      4'h5: begin o = a | b; fl = 5'b00100; end
      4'h6: begin o = ~(a & b); fl = 5'b00100; end
      4'h7: begin o = ~(a | b); fl = 5'b00100; end
      4'h8: begin o = a ^ b; fl = 5'b00100; end
      4'h9: begin o = ~(a ^ b); fl = 5'b00100; end
      4'hA: begin o = (a == b) ? 16'd1 : 16'd0; fl = 5'b00010; end
      4'hB: begin o = (a > b) ? 16'd2 : 16'd0; fl = 5'b00010; end
      4'hC: begin o = (a < b) ? 16'd3 : 16'd0; fl = 5'b00010; end
      4'hD: begin o = a >> 1; fl = 5'b00001; end
      4'hE: begin o = a << 1; fl = 5'b00001; end
      default: begin o = 16'h0; fl = 5'b0; end
    endcase
    return {fl, o};
  endfunction

  always @(posedge clk) begin
    logic [20:0] r;
    r = alu_f(alu_fun, alu_a, alu_b);
    alu_out <= r[15:0] ^ {15'b0, force_bad};
    {alu_carry, alu_arith, alu_logic, alu_cmp, alu_shift} <= r[20:16];
  end

  // Issue one command from a negedge; returns at the negedge where rsp_valid is seen.
  task automatic do_cmd(input logic [3:0] f, input logic [15:0] a, input logic [15:0] b,
                        input bit keep, output int lat, output int acc, output bit to);
    int n;
    to = 1'b0; lat = 0;
    cmd_fun = f; cmd_a = a; cmd_b = b; cmd_valid = 1'b1;
    n = 0;
    while (!cmd_ready && n < 20) begin @(negedge clk); n++; end
    acc = cyc;
    if (!cmd_ready) begin to = 1'b1; cmd_valid = 1'b0; return; end
    @(negedge clk);
    if (!keep) cmd_valid = 1'b0;
    n = 0;
    while (!rsp_valid && n < 20) begin @(negedge clk); n++; end
    if (!rsp_valid) to = 1'b1;
    lat = cyc - acc;
  endtask

  task automatic test_reset;
    rst = 1'b1; cmd_valid = 1'b0; rsp_ready = 1'b1;
    cmd_fun = 4'h0; cmd_a = 16'h0; cmd_b = 16'h0;
    repeat (2) @(posedge clk);
    @(negedge clk); rst = 1'b0;
    tests++;
    if ({alu_a, alu_b, alu_fun} !== {16'h0, 16'h0, 4'hF}) begin
      fails++; $display("FAIL reset_alu: got %h/%h/%h want 0000/0000/f", alu_a, alu_b, alu_fun);
    end
    tests++;
    if ({rsp_valid, rsp_data, rsp_flags, rsp_err} !== {1'b0, 16'h0, 5'h0, 1'b0}) begin
      fails++; $display("FAIL reset_rsp: got v=%b d=%h f=%b e=%b want all zero", rsp_valid, rsp_data, rsp_flags, rsp_err);
    end
    tests++;
    if ({txn_count, err_count, cmd_ready, busy} !== {16'h0, 8'h0, 1'b1, 1'b0}) begin
      fails++; $display("FAIL reset_ctl: got txn=%0d err=%0d rdy=%b busy=%b want 0 0 1 0", txn_count, err_count, cmd_ready, busy);
    end
  endtask

  task automatic test_add;
    int lat, acc; bit to;
    do_cmd(4'h0, 16'd8, 16'd4, 1'b0, lat, acc, to);
    tests++;
    if (to || lat != 3) begin
      fails++; $display("FAIL add_latency: got %0d (timeout=%b) want 3", lat, to);
    end
    tests++;
    if ({rsp_data, rsp_flags} !== {16'h000C, 5'b01000}) begin
      fails++; $display("FAIL add_result: got %h/%b want 000c/01000", rsp_data, rsp_flags);
    end
    @(negedge clk);
    tests++;
    if ({txn_count, cmd_ready, rsp_valid} !== {16'd1, 1'b1, 1'b0}) begin
      fails++; $display("FAIL add_done: got txn=%0d rdy=%b v=%b want 1 1 0", txn_count, cmd_ready, rsp_valid);
    end
  endtask

  task automatic test_div_zero;
    int lat, acc; bit to;
    do_cmd(4'h3, 16'd8, 16'd0, 1'b0, lat, acc, to);
    tests++;
    if (to || {rsp_data, rsp_flags, rsp_err} !== {16'h0, 5'b01000, 1'b0}) begin
      fails++; $display("FAIL div0: got %h/%b err=%b (timeout=%b) want 0000/01000 err=0", rsp_data, rsp_flags, rsp_err, to);
    end
    @(negedge clk);
  endtask

  task automatic test_backpressure;
    int lat, acc; bit to; bit bad;
    rsp_ready = 1'b0;
    do_cmd(4'hA, 16'd8, 16'd8, 1'b0, lat, acc, to);
    bad = to;
    for (int i = 0; i < 5; i++) begin
      if ({rsp_valid, rsp_data, rsp_flags, cmd_ready, busy} !== {1'b1, 16'h1, 5'b00010, 1'b0, 1'b1}) bad = 1'b1;
      @(negedge clk);
    end
    tests++;
    if (bad) begin
      fails++; $display("FAIL bp_hold: got v=%b d=%h f=%b rdy=%b want 1 0001 00010 0 (timeout=%b)", rsp_valid, rsp_data, rsp_flags, cmd_ready, to);
    end
    rsp_ready = 1'b1;
    @(negedge clk);
    tests++;
    if ({cmd_ready, rsp_valid, busy, txn_count} !== {1'b1, 1'b0, 1'b0, 16'd3}) begin
      fails++; $display("FAIL bp_release: got rdy=%b v=%b busy=%b txn=%0d want 1 0 0 3", cmd_ready, rsp_valid, busy, txn_count);
    end
  endtask

  task automatic test_reset_in_wait;
    bit seen;
    cmd_fun = 4'hE; cmd_a = 16'd8; cmd_b = 16'd4; cmd_valid = 1'b1;
    @(negedge clk);
    cmd_valid = 1'b0;
    tests++;
    if (busy !== 1'b1) begin
      fails++; $display("FAIL rw_accept: got busy=%b want 1", busy);
    end
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    tests++;
    if ({alu_fun, txn_count, cmd_ready, rsp_valid} !== {4'hF, 16'd0, 1'b1, 1'b0}) begin
      fails++; $display("FAIL rw_state: got fun=%h txn=%0d rdy=%b v=%b want f 0 1 0", alu_fun, txn_count, cmd_ready, rsp_valid);
    end
    seen = 1'b0;
    repeat (6) begin @(negedge clk); if (rsp_valid !== 1'b0) seen = 1'b1; end
    tests++;
    if (seen) begin
      fails++; $display("FAIL rw_no_rsp: got rsp_valid=1 want 0");
    end
  endtask

  task automatic test_back_to_back;
    logic [3:0]  tf[20] = '{4'h0,4'h1,4'h2,4'h3,4'h4,4'h5,4'h6,4'h7,4'h8,4'h9,
                            4'hA,4'hB,4'hC,4'hD,4'hE,4'hF,4'hC,4'h1,4'h0,4'hE};
    logic [15:0] ta[20] = '{16'd8,16'd8,16'd8,16'd8,16'd8,16'd8,16'd8,16'd8,16'd8,16'd8,
                            16'd8,16'd8,16'd8,16'd8,16'd8,16'd8,16'd4,16'd4,16'hFFFF,16'h8000};
    logic [15:0] tb[20] = '{16'd4,16'd4,16'd4,16'd4,16'd4,16'd4,16'd4,16'd4,16'd4,16'd4,
                            16'd4,16'd4,16'd4,16'd4,16'd4,16'd4,16'd8,16'd8,16'd1,16'd4};
    logic [15:0] td[20] = '{16'h000C,16'h0004,16'h0020,16'h0002,16'h0000,16'h000C,16'hFFFF,16'hFFF3,
                            16'h000C,16'hFFF3,16'h0000,16'h0002,16'h0000,16'h0004,16'h0010,16'h0000,
                            16'h0003,16'hFFFC,16'h0000,16'h0000};
    logic [4:0]  tg[20] = '{5'b01000,5'b01000,5'b01000,5'b01000,5'b00100,5'b00100,5'b00100,5'b00100,
                            5'b00100,5'b00100,5'b00010,5'b00010,5'b00010,5'b00001,5'b00001,5'b00000,
                            5'b00010,5'b11000,5'b11000,5'b00001};
    int lat, acc, prev; bit to;
    prev = 0;
    for (int i = 0; i < 20; i++) begin
      do_cmd(tf[i], ta[i], tb[i], 1'b1, lat, acc, to);
      tests++;
      if (to || {rsp_data, rsp_flags} !== {td[i], tg[i]}) begin
        fails++; $display("FAIL b2b_result[%0d]: got %h/%b want %h/%b (timeout=%b)", i, rsp_data, rsp_flags, td[i], tg[i], to);
      end
      if (i > 0) begin
        tests++;
        if (acc - prev != 4) begin
          fails++; $display("FAIL b2b_interval[%0d]: got %0d want 4", i, acc - prev);
        end
      end
      prev = acc;
    end
    cmd_valid = 1'b0;
    @(negedge clk);
    tests++;
    if ({txn_count, err_count} !== {16'd20, 8'd0}) begin
      fails++; $display("FAIL b2b_count: got txn=%0d err=%0d want 20 0", txn_count, err_count);
    end
  endtask

`ifdef ALU_DRV_CHECK_EN
  task automatic test_check;
    int lat, acc; bit to; bit anyto;
    force_bad = 1'b1;
    do_cmd(4'h0, 16'd8, 16'd4, 1'b0, lat, acc, to);
    tests++;
    if (to || {rsp_data, rsp_err} !== {16'h000D, 1'b1}) begin
      fails++; $display("FAIL chk_err: got d=%h err=%b want 000d 1 (timeout=%b)", rsp_data, rsp_err, to);
    end
    @(negedge clk);
    tests++;
    if (err_count !== 8'd1) begin
      fails++; $display("FAIL chk_count1: got %0d want 1", err_count);
    end
    anyto = 1'b0;
    for (int i = 0; i < 299; i++) begin
      do_cmd(4'h0, 16'd8, 16'd4, 1'b0, lat, acc, to);
      if (to) anyto = 1'b1;
    end
    @(negedge clk);
    tests++;
    if (anyto || err_count !== 8'hFF) begin
      fails++; $display("FAIL chk_sat: got %h want ff (timeout=%b)", err_count, anyto);
    end
    force_bad = 1'b0;
    do_cmd(4'h0, 16'd8, 16'd4, 1'b0, lat, acc, to);
    tests++;
    if (to || {rsp_err, err_count} !== {1'b0, 8'hFF}) begin
      fails++; $display("FAIL chk_clean: got err=%b cnt=%h want 0 ff", rsp_err, err_count);
    end
    @(negedge clk);
  endtask
`endif

  initial begin
    test_reset();
    test_add();
    test_div_zero();
    test_backpressure();
    test_reset_in_wait();
    test_back_to_back();
`ifdef ALU_DRV_CHECK_EN
    test_check();
`endif
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
